divider_32_bit_seq: RTL and testbench



---
 rtl/fp_arith_pkg.sv | 14 +
 rtl/divider_32_bit_seq_if.sv | 27 ++
 rtl/divider_32_bit_seq_div_step.sv | 24 ++
 rtl/divider_32_bit_seq.sv | 104 ++++++++++
 tb/tb_divider_32_bit_seq.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_arith_pkg.sv
// Shared types and sizes for the arithmetic datapath blocks.
// Holds the divider FSM encoding and its default widths.
package fp_arith_pkg;

    localparam int DIV_W  = 32;
    localparam int DIV_CW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider_32_bit_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
// master drives operands and consumes results; slave is the divider.
interface divider_32_bit_seq_if
    import fp_arith_pkg::*;
#(
    parameter int W = DIV_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/divider_32_bit_seq_div_step.sv
// One combinational restoring-division iteration: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if it fits.
module div_step
    import fp_arith_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] rem,
    input  logic         q_msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W:0] t;
    logic [W:0] diff;

    always_comb begin
        t    = {rem, q_msb};
        diff = t - {1'b0, divisor};
        // A clear sign bit means the trial subtraction did not underflow.
        q_bit    = ~diff[W];
        rem_next = diff[W] ? t[W-1:0] : diff[W-1:0];
    end
endmodule

// File: rtl/divider_32_bit_seq.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock,
// with valid/ready handshakes on operands and results.
module divider_32_bit_seq
    import fp_arith_pkg::*;
#(
    parameter int W  = DIV_W,
    parameter int CW = DIV_CW
) (
    input  logic                clk,
    input  logic                rst,
    divider_32_bit_seq_if.slave bus
);
    div_state_t    state_reg;
    logic [W-1:0]  q_reg;
    logic [W-1:0]  rem_reg;
    logic [W-1:0]  divisor_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  quotient_reg;
    logic [W-1:0]  remainder_reg;
    logic          div_zero_reg;
    logic          in_ready_reg;
    logic          out_valid_reg;

    logic [W-1:0]  rem_next;
    logic          q_bit;
    logic [W-1:0]  q_next;

    div_step #(.W(W)) u_step (
        .rem      (rem_reg),
        .q_msb    (q_reg[W-1]),
        .divisor  (divisor_reg),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign q_next = {q_reg[W-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            q_reg         <= '0;
            rem_reg       <= '0;
            divisor_reg   <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        q_reg        <= bus.dividend;
                        divisor_reg  <= bus.divisor;
                        rem_reg      <= '0;
                        cnt_reg      <= CW'(W);
                        div_zero_reg <= (bus.divisor == '0);
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    // Divide-by-zero spends a single RUN cycle so its result
                    // appears one clock after accept, with the dividend still in q_reg.
                    if (div_zero_reg) begin
                        quotient_reg  <= '1;
                        remainder_reg <= q_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        rem_reg <= rem_next;
                        q_reg   <= q_next;
                        cnt_reg <= cnt_reg - CW'(1);
                        if (cnt_reg == CW'(1)) begin
                            quotient_reg  <= q_next;
                            remainder_reg <= rem_next;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.div_zero  = div_zero_reg;
endmodule

// File: tb/tb_divider_32_bit_seq.sv
// Directed and small randomised checks of the sequential divider:
// latency, results, divide-by-zero, backpressure and mid-run reset.
module tb_divider_32_bit_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    divider_32_bit_seq_if #(.W(32)) bus ();

    divider_32_bit_seq #(.W(32), .CW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair for exactly one edge (the accept edge T).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Count edges after accept until out_valid is seen; bounded at 200.
    task automatic wait_done(input int start, output int lat, output bit ready_seen);
        lat        = start;
        ready_seen = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) ready_seen = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got %h want 0", bus.quotient); end
        checks++;
        if (bus.remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got %h want 0", bus.remainder); end
        checks++;
        if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %b want 0", bus.div_zero); end
        $display("reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
    endtask

    task automatic test_basic();
        int lat;
        bit rs;
        start_op(32'd100, 32'd7);
        wait_done(0, lat, rs);
        $display("op 100/7 -> q=%0d r=%0d dz=%b lat=%0d", bus.quotient, bus.remainder, bus.div_zero, lat);
        checks++;
        if (lat !== 32) begin errors++; $display("FAIL basic_latency got %0d want 32", lat); end
        checks++;
        if (bus.quotient !== 32'd14) begin errors++; $display("FAIL basic_quotient got %0d want 14", bus.quotient); end
        checks++;
        if (bus.remainder !== 32'd2) begin errors++; $display("FAIL basic_remainder got %0d want 2", bus.remainder); end
        checks++;
        if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL basic_div_zero got %b want 0", bus.div_zero); end
        checks++;
        if (rs !== 1'b0) begin errors++; $display("FAIL basic_in_ready_busy got %b want 0", rs); end
        consume();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_consume got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_edges();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] vq [3];
        logic [31:0] vr [3];
        int lat;
        bit rs;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h1;         vq[0] = 32'hFFFF_FFFF; vr[0] = 32'h0;
        va[1] = 32'd5;         vb[1] = 32'd9;         vq[1] = 32'd0;         vr[1] = 32'd5;
        va[2] = 32'h8000_0000; vb[2] = 32'hFFFF_FFFF; vq[2] = 32'd0;         vr[2] = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            start_op(va[i], vb[i]);
            wait_done(0, lat, rs);
            $display("op %h/%h -> q=%h r=%h lat=%0d", va[i], vb[i], bus.quotient, bus.remainder, lat);
            checks++;
            if (bus.quotient !== vq[i]) begin errors++; $display("FAIL edge%0d_quotient got %h want %h", i, bus.quotient, vq[i]); end
            checks++;
            if (bus.remainder !== vr[i]) begin errors++; $display("FAIL edge%0d_remainder got %h want %h", i, bus.remainder, vr[i]); end
            checks++;
            if (lat !== 32) begin errors++; $display("FAIL edge%0d_latency got %0d want 32", i, lat); end
            consume();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        bit rs;
        start_op(32'd1234, 32'd0);
        wait_done(0, lat, rs);
        $display("op 1234/0 -> q=%h r=%0d dz=%b lat=%0d", bus.quotient, bus.remainder, bus.div_zero, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
        checks++;
        if (bus.quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_quotient got %h want ffffffff", bus.quotient); end
        checks++;
        if (bus.remainder !== 32'd1234) begin errors++; $display("FAIL dz_remainder got %0d want 1234", bus.remainder); end
        checks++;
        if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", bus.div_zero); end
        consume();
        start_op(32'd8, 32'd2);
        checks++;
        if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear_on_accept got %b want 0", bus.div_zero); end
        wait_done(0, lat, rs);
        $display("op 8/2 -> q=%0d r=%0d dz=%b lat=%0d", bus.quotient, bus.remainder, bus.div_zero, lat);
        checks++;
        if (bus.quotient !== 32'd4 || bus.remainder !== 32'd0) begin
            errors++;
            $display("FAIL dz_next_result got q=%0d r=%0d want 4 0", bus.quotient, bus.remainder);
        end
        checks++;
        if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL dz_next_flag got %b want 0", bus.div_zero); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        bit rs;
        start_op(32'd77, 32'd10);
        bus.dividend = 32'd999;
        bus.divisor  = 32'd3;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.in_valid = 1'b0;
        wait_done(5, lat, rs);
        $display("op 77/10 -> q=%0d r=%0d lat=%0d (stalled)", bus.quotient, bus.remainder, lat);
        checks++;
        if (lat !== 32) begin errors++; $display("FAIL bp_latency got %0d want 32", lat); end
        bus.dividend = 32'd500;
        bus.divisor  = 32'd0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.quotient !== 32'd7 || bus.remainder !== 32'd7 || bus.div_zero !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b q=%0d r=%0d dz=%b want 1 7 7 0", i, bus.out_valid, bus.quotient, bus.remainder, bus.div_zero);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        consume();
        checks++;
        if (bus.quotient !== 32'd7 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_after_consume got q=%0d v=%b want 7 0", bus.quotient, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit rs;
        bit seen;
        start_op(32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("reset during RUN: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flags got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
            errors++;
            $display("FAIL midrst_outputs got q=%h r=%h want 0 0", bus.quotient, bus.remainder);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_pulse got %b want 0", seen); end
        start_op(32'd50, 32'd5);
        wait_done(0, lat, rs);
        $display("op 50/5 -> q=%0d r=%0d lat=%0d", bus.quotient, bus.remainder, lat);
        checks++;
        if (bus.quotient !== 32'd10 || bus.remainder !== 32'd0 || lat !== 32) begin
            errors++;
            $display("FAIL midrst_next got q=%0d r=%0d lat=%0d want 10 0 32", bus.quotient, bus.remainder, lat);
        end
        consume();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        int lat;
        bit rs;
        int stall;
        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            eq = a / b;
            er = a % b;
            start_op(a, b);
            wait_done(0, lat, rs);
            $display("rand %0d: %h/%h -> q=%h r=%h lat=%0d", n, a, b, bus.quotient, bus.remainder, lat);
            checks++;
            if (bus.quotient !== eq || bus.remainder !== er) begin
                errors++;
                $display("FAIL rand%0d_result got q=%h r=%h want q=%h r=%h", n, bus.quotient, bus.remainder, eq, er);
            end
            checks++;
            if (64'(bus.quotient) * 64'(b) + 64'(bus.remainder) !== 64'(a) || bus.remainder >= b) begin
                errors++;
                $display("FAIL rand%0d_invariant got q=%h r=%h for %h/%h", n, bus.quotient, bus.remainder, a, b);
            end
            checks++;
            if (lat !== 32) begin errors++; $display("FAIL rand%0d_latency got %0d want 32", n, lat); end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) tick();
            consume();
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
